// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port main-memory arbiter:
// FSM state encoding and requester IDs.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_t;

  localparam logic PORT0 = 1'b0;  // CPU memory stage
  localparam logic PORT1 = 1'b1;  // program loader / debug

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: the favoured port wins ties,
// and a lone requester always wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       win
);

  always_comb begin
    win = PORT0;
    if (req[0] && req[1]) begin
      win = ptr;
    end else if (req[1]) begin
      win = PORT1;
    end
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = win ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between the CPU (port 0) and the
// loader/debug port (port 1); one transaction per 3 cycles, round-robin fair.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output arb_state_t        dbg_state
);

  // Handshake: a requester raises pN_req with we/addr/wdata stable and holds
  // them until pN_gnt is seen high in a cycle; the request is consumed at that
  // clock edge. Completion is a single-cycle pN_rvalid pulse two cycles later.

  arb_state_t        state_q, state_d;
  logic              ptr_q, owner_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  logic [1:0]        pick_gnt;
  logic              pick_win;
  logic              accept, resp;

  rr_pick2 u_pick (
    .req ({p1_req, p0_req}),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .win (pick_win)
  );

  assign accept = (state_q == IDLE) && (p0_req || p1_req) && !reset;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= PORT0;
      owner_q  <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= pick_win;
        ptr_q   <= ~pick_win;
        we_q    <= (pick_win == PORT1) ? p1_we    : p0_we;
        addr_q  <= (pick_win == PORT1) ? p1_addr  : p0_addr;
        wdata_q <= (pick_win == PORT1) ? p1_wdata : p0_wdata;
      end
      // Keep the last read value so rdata stays stable between responses.
      if (state_q == RESP && !we_q) begin
        if (owner_q == PORT0) rdata0_q <= mem_rdata;
        else                  rdata1_q <= mem_rdata;
      end
    end
  end

  assign p0_gnt = accept && pick_gnt[0];
  assign p1_gnt = accept && pick_gnt[1];

  // Reset gates the response and the write strobe so a dropped transaction
  // neither completes nor commits.
  assign resp      = (state_q == RESP) && !reset;
  assign p0_rvalid = resp && (owner_q == PORT0);
  assign p1_rvalid = resp && (owner_q == PORT1);
  assign p0_rdata  = (p0_rvalid && !we_q) ? mem_rdata : rdata0_q;
  assign p1_rdata  = (p1_rvalid && !we_q) ? mem_rdata : rdata1_q;

  assign mem_we    = (state_q == ACCESS) && we_q && !reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 256x8 sync-read
// memory and a per-port scoreboard of expected responses.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p0_req = 1'b0, p0_we = 1'b0;
  logic [7:0] p0_addr = '0, p0_wdata = '0;
  logic       p0_gnt, p0_rvalid;
  logic [7:0] p0_rdata;
  logic       p1_req = 1'b0, p1_we = 1'b0;
  logic [7:0] p1_addr = '0, p1_wdata = '0;
  logic       p1_gnt, p1_rvalid;
  logic [7:0] p1_rdata;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       busy;
  arb_state_t dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = '0, bd_data = '0;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  int         glog[$];
  int         gcyc[$];

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  // External memory: synchronous read, with a bench-only preload port.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    ref_mem[addr] = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic push_exp(input int port, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    logic [8:0] e;
    if (we) begin
      ref_mem[addr] = wd;
      e = {1'b0, wd};
    end else begin
      e = {1'b1, ref_mem[addr]};
    end
    if (port == 0) exp_q0.push_back(e);
    else           exp_q1.push_back(e);
  endtask

  // Driver: call just after a rising edge; returns just after the edge that
  // consumes the request, with gcycle set to the grant cycle.
  task automatic issue(input int port, input logic we, input logic [7:0] addr,
                       input logic [7:0] wd, input bit track, output int gcycle);
    bit got;
    got = 1'b0;
    gcycle = -1;
    if (port == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    else           begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port == 0 && p0_gnt) || (port == 1 && p1_gnt)) begin
        got = 1'b1;
        gcycle = cyc;
        if (track) push_exp(port, we, addr, wd);
      end
    end
    check("gnt_seen", 32'(got), 1);
    @(posedge clk);
    #1;
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    logic [8:0] e;
    if (p0_gnt || p1_gnt) begin
      check("gnt_onehot", 32'(p0_gnt & p1_gnt), 0);
      glog.push_back(p1_gnt ? 1 : 0);
      gcyc.push_back(cyc);
    end
    if (p0_rvalid) begin
      check("p0_rvalid_expected", 32'(exp_q0.size() != 0), 1);
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        if (e[8]) check("p0_rdata", 32'(p0_rdata), 32'(e[7:0]));
      end
    end
    if (p1_rvalid) begin
      check("p1_rvalid_expected", 32'(exp_q1.size() != 0), 1);
      if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        if (e[8]) check("p1_rdata", 32'(p1_rdata), 32'(e[7:0]));
      end
    end
  end

  initial begin
    int t, t1;
    logic [7:0] laddr [3];
    logic [7:0] ldata [3];

    apply_reset();
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 0);
    check("rst_rdata", 32'({p0_rdata, p1_rdata}), 0);
    @(posedge clk); #1;

    preload(8'h10, 8'h5A);
    preload(8'h20, 8'h11);

    // Single read
    issue(0, 1'b0, 8'h10, 8'h00, 1'b1, t);
    @(negedge clk);
    check("rd_access_addr", 32'(mem_addr), 'h10);
    check("rd_access_state", 32'(dbg_state), 32'(ACCESS));
    check("rd_access_we", 32'(mem_we), 0);
    check("rd_access_busy", 32'(busy), 1);
    check("rd_access_rvalid", 32'(p0_rvalid), 0);
    @(negedge clk);
    check("rd_resp_rvalid", 32'(p0_rvalid), 1);
    check("rd_resp_rdata", 32'(p0_rdata), 'h5A);
    check("rd_resp_p1_rvalid", 32'(p1_rvalid), 0);
    @(negedge clk);
    check("rd_done_busy", 32'(busy), 0);
    check("rd_done_rvalid", 32'(p0_rvalid), 0);
    @(posedge clk); #1;

    // Write 0xC3 to 0xFF from port 1, then read it back on port 0
    issue(1, 1'b1, 8'hFF, 8'hC3, 1'b1, t);
    @(negedge clk);
    check("wr_access_we", 32'(mem_we), 1);
    check("wr_access_addr", 32'(mem_addr), 'hFF);
    check("wr_access_wdata", 32'(mem_wdata), 'hC3);
    @(negedge clk);
    check("wr_resp_we", 32'(mem_we), 0);
    check("wr_resp_p1_rvalid", 32'(p1_rvalid), 1);
    check("wr_resp_p0_rvalid", 32'(p0_rvalid), 0);
    @(posedge clk); #1;
    check("wr_mem_content", 32'(mem[8'hFF]), 'hC3);
    issue(0, 1'b0, 8'hFF, 8'h00, 1'b1, t);
    @(negedge clk);
    @(negedge clk);
    check("wr_readback", 32'(p0_rdata), 'hC3);
    @(posedge clk); #1;

    // Contention from reset: p0, p1, p0, p1 at 3-cycle spacing
    apply_reset();
    glog.delete(); gcyc.delete();
    fork
      begin
        int g;
        issue(0, 1'b0, 8'h10, 8'h00, 1'b1, g);
        issue(0, 1'b0, 8'hFF, 8'h00, 1'b1, g);
      end
      begin
        int g;
        issue(1, 1'b0, 8'hFF, 8'h00, 1'b1, g);
        issue(1, 1'b0, 8'h10, 8'h00, 1'b1, g);
      end
    join
    repeat (4) @(negedge clk);
    check("cont_ngrants", 32'(glog.size()), 4);
    for (int i = 0; i < glog.size(); i++) begin
      check("cont_order", 32'(glog[i]), 32'(i % 2));
      if (i > 0) check("cont_spacing", 32'(gcyc[i] - gcyc[i-1]), 3);
    end
    @(posedge clk); #1;

    // Lone requester: three p1 writes, no pointer stall
    glog.delete(); gcyc.delete();
    for (int i = 0; i < 3; i++) begin
      laddr[i] = 8'(8'h40 + $urandom_range(0, 15) * 4 + i);
      ldata[i] = 8'($urandom_range(0, 255));
      issue(1, 1'b1, laddr[i], ldata[i], 1'b1, t);
    end
    repeat (3) @(negedge clk);
    check("lone_ngrants", 32'(glog.size()), 3);
    for (int i = 0; i < glog.size(); i++) begin
      check("lone_port", 32'(glog[i]), 1);
      if (i > 0) check("lone_spacing", 32'(gcyc[i] - gcyc[i-1]), 3);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) issue(0, 1'b0, laddr[i], 8'h00, 1'b1, t);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // Reset in the ACCESS cycle of a p0 write
    issue(0, 1'b1, 8'h20, 8'h77, 1'b0, t);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_mem_we", 32'(mem_we), 0);
    check("rstmid_rvalid", 32'(p0_rvalid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_state", 32'(dbg_state), 32'(IDLE));
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_mem", 32'(mem[8'h20]), 'h11);
    @(negedge clk);
    check("rstmid_no_rvalid", 32'(p0_rvalid), 0);
    @(posedge clk); #1;
    glog.delete(); gcyc.delete();
    fork
      begin int g; issue(0, 1'b0, 8'h20, 8'h00, 1'b1, g); end
      begin int g; issue(1, 1'b0, 8'h10, 8'h00, 1'b1, g); end
    join
    repeat (4) @(negedge clk);
    check("rstmid_ptr_ngrants", 32'(glog.size()), 2);
    if (glog.size() > 0) check("rstmid_ptr_first", 32'(glog[0]), 0);
    @(posedge clk); #1;

    // p1 request raised in the RESP cycle of a p0 transaction
    issue(0, 1'b0, 8'h10, 8'h00, 1'b1, t);
    @(posedge clk); #1;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'hFF; p1_wdata = 8'h00;
    @(negedge clk);
    check("busyreq_state", 32'(dbg_state), 32'(RESP));
    check("busyreq_no_gnt", 32'(p1_gnt), 0);
    issue(1, 1'b0, 8'hFF, 8'h00, 1'b1, t1);
    check("busyreq_gnt_cycle", 32'(t1 - t), 3);

    repeat (6) @(negedge clk);
    check("drain_q0", 32'(exp_q0.size()), 0);
    check("drain_q1", 32'(exp_q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 256x8 main memory between the CPU's memory stage and a second requester: the program loader / debug port. It accepts one request at a time through a req/gnt handshake and sequences the memory's address, write-enable and write-data lines. It returns read data, or a write acknowledge, to the owner of the transaction. Fairness is round-robin, so neither requester starves the other.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- p0_req  in  1  port 0 (CPU) request; held with p0_we/p0_addr/p0_wdata stable until p0_gnt
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_gnt  out  1  port 0 request accepted this cycle
- p0_rvalid  out  1  port 0 transaction complete; p0_rdata valid if read
- p0_rdata  out  DATA_W  port 0 read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1 (loader/debug)
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid the cycle after mem_addr is presented
- busy  out  1  arbiter not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when any req is high, the arbiter picks a winner and asserts that port's gnt combinationally in the same cycle. It latches the winner's we, addr and wdata, plus the owner ID, then moves to ACCESS. With no req, it stays in IDLE.
- Round-robin rule: a priority pointer names the favoured port. If both ports request, the favoured port wins. A lone requester wins regardless of the pointer. On each grant, the pointer moves to the other port.
- ACCESS: drive mem_addr, mem_wdata and mem_we from the latched values. The write commits at the end of this cycle. Next state is RESP.
- RESP: the owner's rvalid is high for exactly one cycle. For a read, the owner's rdata equals mem_rdata. For a write, rdata is don't-care, but rvalid is still pulsed. Next state is IDLE.
- A new request is accepted only in IDLE. A req arriving during ACCESS or RESP waits, with its inputs held.
- Outside ACCESS: mem_we is 0, and mem_addr/mem_wdata hold the latched values.

## Timing
- Grant in cycle t. Memory access in t+1. rvalid in t+2. The next grant is possible in t+3. Throughput is 1 transaction per 3 cycles.
- gnt is combinational from req and state. rvalid, rdata, mem_* and busy depend only on registered state (no combinational path from req).
- Reset values: state IDLE, priority pointer on port 0, all gnt/rvalid 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, busy 0.
- Reset mid-transaction (in ACCESS or RESP): the transaction is dropped. No rvalid is issued, and mem_we is forced to 0 in any cycle where reset is high, so no write commits. The CPU's own reset must be asserted together with the arbiter's reset.
- Simultaneous requests in IDLE: exactly one gnt is high, per the priority pointer. The losing port keeps req high and is granted on its next IDLE visit.
- Address wrap: addresses are passed through unmodified. Address 0xFF is valid, and the arbiter performs no address arithmetic.
- Back-to-back requests from one port with the other idle are granted every 3 cycles, despite the pointer.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10
  - port ID constants: PORT0=1'b0, PORT1=1'b1
- Sub-module `rr_pick2`: combinational 2-way round-robin picker. Inputs are the two req lines and the pointer. Outputs are a one-hot grant and the winner ID.
- The memory instance lives outside this block. The CPU's memory stage connects to port 0.

## Test plan
- Single read:
  - Preload mem[0x10]=0x5A.
  - p0 read addr 0x10 -> p0_gnt in t, mem_addr=0x10 in t+1, p0_rvalid=1 and p0_rdata=0x5A in t+2, busy back to 0 in t+3.
- Write then read:
  - p1 writes 0xC3 to 0xFF -> mem_we=1 only in the ACCESS cycle, p1_rvalid pulse.
  - p0 then reads 0xFF -> p0_rdata=0xC3.
- Contention:
  - p0 and p1 both hold reads from reset -> grant order p0, p1, p0, p1.
  - Grants are 3 cycles apart, and each rvalid goes only to its owner.
- Lone requester: p1 issues 3 consecutive writes while p0 is idle -> all 3 are granted at 3-cycle spacing, with no stall from the pointer.
- Reset mid-write:
  - p0 write 0x77 to 0x20 is granted; reset is asserted in the ACCESS cycle.
  - Required: mem_we=0 in that cycle, mem[0x20] unchanged, and no p0_rvalid.
  - After reset: state IDLE, and the pointer favours p0.
- Request during busy: p1 raises req in the RESP cycle of a p0 transaction -> p1_gnt is asserted on the following IDLE cycle, not before.
